// File: rtl/spi_dcd_pkg.sv
// Shared definitions for the SPI burst decoder: header layout, FSM states
// and the burst address step.
package spi_dcd_pkg;

    localparam int HDR_WR_BIT    = 7;
    localparam int HDR_BURST_BIT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Addresses are handled at the maximum 6-bit width; callers truncate.
    function automatic logic [5:0] addr_inc(input logic [5:0] a, input logic [5:0] last);
        return (a == last) ? 6'd0 : a + 6'd1;
    endfunction

endpackage

// File: rtl/spi_burst_dcd_rd_lat_pipe.sv
// Delays the register read strobe by READ_LAT cycles to form the data_out
// capture enable. Reset flushes any capture in flight.
module rd_lat_pipe #(
    parameter int READ_LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_i,
    output logic cap_o
);

    if (READ_LAT == 0) begin : g_comb
        logic unused_pipe;
        assign unused_pipe = clk ^ rst_n;
        assign cap_o       = rd_i;
    end else begin : g_pipe
        logic [READ_LAT-1:0] vld_pipe_q;
        always_ff @(posedge clk) begin
            if (!rst_n) vld_pipe_q <= '0;
            else        vld_pipe_q <= (vld_pipe_q << 1) | READ_LAT'(rd_i);
        end
        assign cap_o = vld_pipe_q[READ_LAT-1];
    end

endmodule

// File: rtl/spi_burst_dcd.sv
// Header + data byte decoder between the SPI slave byte interface and the
// register file, with auto-increment bursts and read prefetch.
module spi_burst_dcd
    import spi_dcd_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int ADDR_LAST = 2**ADDR_W - 1,
    parameter int READ_LAT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_active,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_read,
    output logic [7:0]        data_write,
    output logic              ovr,
    output logic              busy
);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          data_out_q, data_write_q;
    logic                burst_q, read_q, write_q, ovr_q, rd_pend_q;
    logic                cap;
    logic [ADDR_W-1:0]   addr_nxt;

    assign addr_nxt = ADDR_W'(addr_inc(6'(addr_q), 6'(ADDR_LAST)));

    rd_lat_pipe #(.READ_LAT(READ_LAT)) u_rd_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_i  (read_q),
        .cap_o (cap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            burst_q      <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            ovr_q        <= 1'b0;
            rd_pend_q    <= 1'b0;
            data_out_q   <= '0;
            data_write_q <= '0;
        end else begin
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            ovr_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            // A capture already in flight completes even across a frame abort.
            if (cap) data_out_q <= data_read;
            if (!cs_active) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (byte_sync) begin
                        addr_q  <= data_in[ADDR_W-1:0];
                        burst_q <= data_in[HDR_BURST_BIT];
                        if (data_in[HDR_WR_BIT]) begin
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                            read_q  <= 1'b1;
                        end
                    end
                    WR: begin
                        if (byte_sync) begin
                            write_q      <= 1'b1;
                            data_write_q <= data_in;
                            if (!burst_q) state_q <= DRAIN;
                        end
                        // Step the address only after the write cycle has used it.
                        if (write_q && burst_q) addr_q <= addr_nxt;
                    end
                    RD: begin
                        if (byte_sync) begin
                            if (burst_q) begin
                                addr_q    <= addr_nxt;
                                rd_pend_q <= 1'b1;
                            end else begin
                                state_q <= DRAIN;
                            end
                        end
                        if (rd_pend_q) read_q <= 1'b1;
                    end
                    DRAIN: if (byte_sync) ovr_q <= 1'b1;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_write = data_write_q;
    assign addr       = addr_q;
    assign read       = read_q;
    assign write      = write_q;
    assign ovr        = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule
